// File: rtl/hdmi_gearbox_buff.sv
// Wide-to-narrow HDMI pixel buffer: bursts of IW-bit upstream words become OW-bit pixels aligned to delayed DE/HS/VS.
// Optional build macro HDMI_GEARBOX_UFCNT_EN adds a saturating per-pixel underflow counter on uf_count.
module hdmi_gearbox_buff #(
    parameter int IW          = 256,
    parameter int PIX_W       = 32,
    parameter int OW          = 16,
    parameter int DEPTH       = 512,
    parameter int BURST       = 240,
    parameter int START_WORDS = 240
) (
    input  logic             hdmi_clk,
    input  logic             sync_rst_n,
    input  logic             hdmi_Pre_de,
    input  logic             hdmi_Pre_hsync,
    input  logic             hdmi_Pre_vsync,
    output logic             fifo_rd_en,
    input  logic [IW-1:0]    fifo_rd_data,
    output logic             hdmi_start,
    output logic             hdmi_Post_en,
    output logic             hdmi_Post_hsync,
    output logic             hdmi_Post_vsync,
    output logic [OW-1:0]    hdmi_rd_data,
    output logic             underflow,
`ifdef HDMI_GEARBOX_UFCNT_EN
    output logic [15:0]      uf_count,
`endif
    output logic [1:0]       state_dbg
);

    localparam int LANES = IW / PIX_W;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int CW1   = CW + 1;
    localparam int BW    = $clog2(BURST + 1);

    // Upstream handshake: fifo_rd_en is a bare strobe with no back-pressure; the word
    // for a strobe in cycle t is valid on fifo_rd_data in cycle t+1 and written at its end.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [IW-1:0]     mem [DEPTH];
    logic [IW-1:0]     head;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     occ, occ_next;
    logic [CW:0]       committed;
    logic              rd_en_d;
    logic [BW-1:0]     burst_cnt;
    logic [LW-1:0]     lane;
    logic              run, pop, uf_evt, retire, vs_rise, start_ok, last_lane;
    logic [PIX_W-1:0]  slot;
    logic [OW-1:0]     pix;

    assign head      = mem[rd_ptr];
    assign run       = (state == RUN);
    assign pop       = hdmi_Pre_de && run && (occ != '0);
    assign uf_evt    = hdmi_Pre_de && run && (occ == '0);
    assign last_lane = (lane == LW'(LANES - 1));
    assign retire    = pop && last_lane;
    assign vs_rise   = hdmi_Pre_vsync && !hdmi_Post_vsync;
    assign occ_next  = occ + CW'(rd_en_d) - CW'(retire);
    assign state_dbg = state;

    // Words already strobed but not yet written still claim FIFO space.
    assign committed = {1'b0, occ} + {{CW{1'b0}}, rd_en_d};
    assign start_ok  = (committed <= CW1'(DEPTH - BURST));

    always_comb begin
        slot = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LW'(i)) slot = head[i*PIX_W +: PIX_W];
        end
    end

    generate
        if (OW == 16) begin : g_rgb565
            logic unused_slot_bits;
            assign pix = {slot[23:19], slot[15:10], slot[7:3]};
            assign unused_slot_bits = ^{slot[PIX_W-1:24], slot[18:16], slot[9:8], slot[2:0]};
        end else begin : g_rgb888
            logic unused_slot_bits;
            assign pix = slot[23:0];
            assign unused_slot_bits = ^slot[PIX_W-1:24];
        end
    endgenerate

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = PRIME;
            PRIME:   if (occ_next >= CW'(START_WORDS)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge hdmi_clk) begin
        if (rd_en_d) mem[wr_ptr] <= fifo_rd_data;
    end

    always_ff @(posedge hdmi_clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state           <= IDLE;
            hdmi_start      <= 1'b0;
            fifo_rd_en      <= 1'b0;
            burst_cnt       <= '0;
            rd_en_d         <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            occ             <= '0;
            lane            <= '0;
            hdmi_Post_en    <= 1'b0;
            hdmi_Post_hsync <= 1'b0;
            hdmi_Post_vsync <= 1'b0;
            hdmi_rd_data    <= '0;
            underflow       <= 1'b0;
`ifdef HDMI_GEARBOX_UFCNT_EN
            uf_count        <= '0;
`endif
        end else begin
            state      <= state_next;
            hdmi_start <= (state_next == RUN);

            // burst_cnt holds the number of strobes issued so far in the current burst
            if (!fifo_rd_en) begin
                if (start_ok) begin
                    fifo_rd_en <= 1'b1;
                    burst_cnt  <= BW'(1);
                end
            end else if (burst_cnt == BW'(BURST)) begin
                fifo_rd_en <= 1'b0;
                burst_cnt  <= '0;
            end else begin
                burst_cnt <= burst_cnt + BW'(1);
            end

            rd_en_d <= fifo_rd_en;
            if (rd_en_d) wr_ptr <= wr_ptr + AW'(1);
            if (retire)  rd_ptr <= rd_ptr + AW'(1);
            occ <= occ_next;
            if (pop) lane <= last_lane ? '0 : lane + LW'(1);

            hdmi_Post_en    <= hdmi_Pre_de;
            hdmi_Post_hsync <= hdmi_Pre_hsync;
            hdmi_Post_vsync <= hdmi_Pre_vsync;
            hdmi_rd_data    <= pop ? pix : '0;

            if (uf_evt)       underflow <= 1'b1;
            else if (vs_rise) underflow <= 1'b0;
`ifdef HDMI_GEARBOX_UFCNT_EN
            if (uf_evt) begin
                if (uf_count != 16'hFFFF) uf_count <= uf_count + 16'd1;
            end else if (vs_rise) begin
                uf_count <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_hdmi_gearbox_buff.sv
// Bench for hdmi_gearbox_buff: a default RGB565 instance and a tiny RGB888 instance that can underflow,
// both checked every cycle against a pixel-queue reference model.
module tb_hdmi_gearbox_buff;

    localparam int LANES_P [2] = '{8, 1};
    localparam int DEPTH_P [2] = '{512, 4};
    localparam int BURST_P [2] = '{240, 2};
    localparam int START_P [2] = '{240, 2};

    logic          hdmi_clk = 1'b0;
    logic          sync_rst_n;
    logic          de, hs, vs;
    logic          rd_a, rd_b;
    logic [255:0]  data_a;
    logic [31:0]   data_b;
    logic          start_a, start_b, en_a, en_b, hs_a, hs_b, vs_a, vs_b, uf_a, uf_b;
    logic [15:0]   pix_a;
    logic [23:0]   pix_b;
    logic [1:0]    st_a, st_b;
`ifdef HDMI_GEARBOX_UFCNT_EN
    logic [15:0]   cnt_a, cnt_b;
`endif

    always #5 hdmi_clk = ~hdmi_clk;

    hdmi_gearbox_buff dut_a (
        .hdmi_clk(hdmi_clk), .sync_rst_n(sync_rst_n),
        .hdmi_Pre_de(de), .hdmi_Pre_hsync(hs), .hdmi_Pre_vsync(vs),
        .fifo_rd_en(rd_a), .fifo_rd_data(data_a), .hdmi_start(start_a),
        .hdmi_Post_en(en_a), .hdmi_Post_hsync(hs_a), .hdmi_Post_vsync(vs_a),
        .hdmi_rd_data(pix_a), .underflow(uf_a),
`ifdef HDMI_GEARBOX_UFCNT_EN
        .uf_count(cnt_a),
`endif
        .state_dbg(st_a)
    );

    hdmi_gearbox_buff #(
        .IW(32), .PIX_W(32), .OW(24), .DEPTH(4), .BURST(2), .START_WORDS(2)
    ) dut_b (
        .hdmi_clk(hdmi_clk), .sync_rst_n(sync_rst_n),
        .hdmi_Pre_de(de), .hdmi_Pre_hsync(hs), .hdmi_Pre_vsync(vs),
        .fifo_rd_en(rd_b), .fifo_rd_data(data_b), .hdmi_start(start_b),
        .hdmi_Post_en(en_b), .hdmi_Post_hsync(hs_b), .hdmi_Post_vsync(vs_b),
        .hdmi_rd_data(pix_b), .underflow(uf_b),
`ifdef HDMI_GEARBOX_UFCNT_EN
        .uf_count(cnt_b),
`endif
        .state_dbg(st_b)
    );

    // scoreboard: expected pixel slots per instance, in emission order
    logic [31:0]  exp_q_a[$];
    logic [31:0]  exp_q_b[$];

    int           n_checks = 0;
    int           n_err = 0;
    int           strobes_a = 0;
    int           m_state [2];
    bit           m_rd [2];
    int           m_rem [2];
    bit           pend [2];
    logic [255:0] pend_w [2];
    bit           rd_s [2];
    bit           use_force [2];
    bit           chk_c [2];
    logic [23:0]  const_v [2];
    int           pops_n [2];
    logic [23:0]  exp_pix [2];
    bit           exp_uf [2];
    bit           exp_start [2];
    logic [15:0]  exp_cnt [2];
    bit           exp_en, exp_hs, exp_vs, vs_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [23:0] to565(input logic [31:0] s);
        int r, g, b;
        r = int'(s[23:16]); g = int'(s[15:8]); b = int'(s[7:0]);
        return 24'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    function automatic logic [23:0] to888(input logic [31:0] s);
        int r, g, b;
        r = int'(s[23:16]); g = int'(s[15:8]); b = int'(s[7:0]);
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    function automatic int qsz(input int k);
        return (k == 0) ? exp_q_a.size() : exp_q_b.size();
    endfunction

    function automatic int words_held(input int k);
        return (qsz(k) + LANES_P[k] - 1) / LANES_P[k];
    endfunction

    task automatic model_reset();
        exp_q_a.delete();
        exp_q_b.delete();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_rd[k] = 0; m_rem[k] = 0; pend[k] = 0; rd_s[k] = 0;
            exp_pix[k] = '0; exp_uf[k] = 0; exp_start[k] = 0; exp_cnt[k] = '0; chk_c[k] = 0;
        end
        exp_en = 0; exp_hs = 0; exp_vs = 0; vs_prev = 0;
    endtask

    task automatic model_step();
        bit          uf_evt, rise;
        int          free;
        logic [31:0] s;
        chk_c[0] = 0;
        chk_c[1] = 0;
        if (!sync_rst_n) return;
        rise = vs && !vs_prev;
        for (int k = 0; k < 2; k++) begin
            free = DEPTH_P[k] - words_held(k) - (pend[k] ? 1 : 0);
            uf_evt = 0;
            exp_pix[k] = '0;
            if (m_state[k] == 2 && de) begin
                if (qsz(k) > 0) begin
                    s = (k == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
                    exp_pix[k] = (k == 0) ? to565(s) : to888(s);
                    if (k == 0 && pops_n[0] < 2) begin
                        chk_c[0] = 1;
                        const_v[0] = (pops_n[0] == 0) ? 24'h00F800 : 24'h0007E0;
                    end
                    if (k == 1 && pops_n[1] == 0) begin
                        chk_c[1] = 1;
                        const_v[1] = 24'h123456;
                    end
                    pops_n[k]++;
                end else begin
                    uf_evt = 1;
                end
            end
            if (uf_evt)    exp_uf[k] = 1;
            else if (rise) exp_uf[k] = 0;
            if (uf_evt) begin
                if (exp_cnt[k] != 16'hFFFF) exp_cnt[k] = exp_cnt[k] + 16'd1;
            end else if (rise) begin
                exp_cnt[k] = '0;
            end
            if (m_rd[k]) begin
                if (m_rem[k] > 0) m_rem[k]--;
                else m_rd[k] = 0;
            end else if (free >= BURST_P[k]) begin
                m_rd[k] = 1;
                m_rem[k] = BURST_P[k] - 1;
            end
            if (pend[k]) begin
                for (int l = 0; l < LANES_P[k]; l++) begin
                    if (k == 0) exp_q_a.push_back(pend_w[0][l*32 +: 32]);
                    else        exp_q_b.push_back(pend_w[1][l*32 +: 32]);
                end
                pend[k] = 0;
            end
            if (rd_s[k]) begin
                pend[k] = 1;
                pend_w[k] = rand_word();
                if (use_force[k]) begin
                    use_force[k] = 0;
                    if (k == 0) begin
                        pend_w[0][31:0]  = 32'h00FF0000;
                        pend_w[0][63:32] = 32'h0000FF00;
                    end else begin
                        pend_w[1][31:0]  = 32'h00123456;
                    end
                end
            end
            if (m_state[k] == 0) m_state[k] = 1;
            else if (m_state[k] == 1 && words_held(k) >= START_P[k]) m_state[k] = 2;
            exp_start[k] = (m_state[k] == 2);
        end
        exp_en = de; exp_hs = hs; exp_vs = vs; vs_prev = vs;
    endtask

    task automatic check_outputs();
        check("en_a", 32'(en_a), 32'(exp_en));
        check("hs_a", 32'(hs_a), 32'(exp_hs));
        check("vs_a", 32'(vs_a), 32'(exp_vs));
        check("en_b", 32'(en_b), 32'(exp_en));
        check("hs_b", 32'(hs_b), 32'(exp_hs));
        check("vs_b", 32'(vs_b), 32'(exp_vs));
        check("pix_a", 32'(pix_a), 32'(exp_pix[0]));
        check("pix_b", 32'(pix_b), 32'(exp_pix[1]));
        check("uf_a", 32'(uf_a), 32'(exp_uf[0]));
        check("uf_b", 32'(uf_b), 32'(exp_uf[1]));
        check("start_a", 32'(start_a), 32'(exp_start[0]));
        check("start_b", 32'(start_b), 32'(exp_start[1]));
        check("rd_en_a", 32'(rd_a), 32'(m_rd[0]));
        check("rd_en_b", 32'(rd_b), 32'(m_rd[1]));
        check("state_a", 32'(st_a), 32'(m_state[0]));
        check("state_b", 32'(st_b), 32'(m_state[1]));
`ifdef HDMI_GEARBOX_UFCNT_EN
        check("uf_count_a", 32'(cnt_a), 32'(exp_cnt[0]));
        check("uf_count_b", 32'(cnt_b), 32'(exp_cnt[1]));
`endif
        if (chk_c[0]) check("rgb565_const", 32'(pix_a), 32'(const_v[0]));
        if (chk_c[1]) check("rgb888_const", 32'(pix_b), 32'(const_v[1]));
    endtask

    task automatic tick(input bit de_n, input bit hs_n, input bit vs_n);
        @(posedge hdmi_clk);
        model_step();
        #1;
        data_a = pend[0] ? pend_w[0] : rand_word();
        data_b = pend[1] ? pend_w[1][31:0] : $urandom();
        de = de_n; hs = hs_n; vs = vs_n;
        @(negedge hdmi_clk);
        check_outputs();
        rd_s[0] = rd_a;
        rd_s[1] = rd_b;
        if (rd_a) strobes_a++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_a"}, 32'(rd_a), 32'd0);
        check({tag, "_start_a"}, 32'(start_a), 32'd0);
        check({tag, "_en_a"}, 32'(en_a), 32'd0);
        check({tag, "_pix_a"}, 32'(pix_a), 32'd0);
        check({tag, "_uf_b"}, 32'(uf_b), 32'd0);
        check({tag, "_pix_b"}, 32'(pix_b), 32'd0);
        check({tag, "_start_b"}, 32'(start_b), 32'd0);
    endtask

    task automatic traffic(input int cycles);
        bit d;
        for (int c = 0; c < cycles; c++) begin
            if (c % 250 < 3) tick(1'b0, 1'b0, 1'b1);
            else begin
                d = ($urandom_range(0, 3) != 0);
                tick(d, (c % 50) == 10, 1'b0);
            end
        end
    endtask

    initial begin
        int waited;
        sync_rst_n = 1'b0;
        de = 0; hs = 0; vs = 0;
        data_a = '0; data_b = '0;
        pops_n[0] = 0; pops_n[1] = 0;
        use_force[0] = 1; use_force[1] = 1;
        model_reset();
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check_all_zero("reset");
        sync_rst_n = 1'b1;

        // priming with DE low: two back-to-back bursts for the default instance
        repeat (560) tick(1'b0, 1'b0, 1'b0);
        check("burst_total_a", 32'(strobes_a), 32'd480);

        // one full line of 1920 pixels after a vsync pulse
        repeat (2) tick(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 1920; c++) tick(1'b1, (c % 200) == 0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b1);
        traffic(1500);

        // reset in the middle of a burst of the default instance
        waited = 0;
        while (!rd_s[0] && waited < 4000) begin
            tick(1'b1, 1'b0, 1'b0);
            waited++;
        end
        check("wait_burst_a", 32'(rd_s[0]), 32'd1);
        tick(1'b1, 1'b0, 1'b0);
        #3 sync_rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        sync_rst_n = 1'b1;
        repeat (560) tick(1'b0, 1'b0, 1'b0);
        traffic(800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
